alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 9 +
 rtl/alu_sequencer_comp2.sv | 9 +
 rtl/alu_sequencer.sv | 91 +++++++++
 tb/tb_alu_sequencer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings, FSM states and flag bit positions for alu_sequencer
package alu_pkg;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_NEG, OP_ABS} op_t;
    typedef enum logic [1:0] {S_IDLE, S_CONV, S_EXEC, S_DONE} state_t;
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 3;
endpackage

// File: rtl/alu_sequencer_comp2.sv
// MOD_Conversor_Comp2: combinational two's complement negation
module MOD_Conversor_Comp2 #(
    parameter int W = 6
) (
    input  logic [W-1:0] A,
    output logic [W-1:0] A_convertido
);
    assign A_convertido = ~A + W'(1);
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle ADD/SUB/NEG/ABS unit (IDLE->CONV->EXEC->DONE) with a start/ack handshake
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         ack,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);
    state_t       r_state, w_next;
    op_t          r_op;
    logic [W-1:0] r_a, r_b, r_conv, r_result;
    logic [3:0]   r_flags;
    logic [W-1:0] w_comp_in, w_comp, w_res;
    logic [W:0]   w_sum;
    logic [3:0]   w_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_CONV : S_IDLE;
            S_CONV:  w_next = S_EXEC;
            S_EXEC:  w_next = S_DONE;
            default: w_next = ack ? S_IDLE : S_DONE;
        endcase
    end

    // Only SUB negates B; NEG and ABS negate A
    assign w_comp_in = (r_op == OP_SUB) ? r_b : r_a;

    MOD_Conversor_Comp2 #(.W(W)) u_comp (
        .A            (w_comp_in),
        .A_convertido (w_comp)
    );

    assign w_sum = {1'b0, r_a} + {1'b0, r_conv};
    assign w_res = (r_op == OP_NEG || (r_op == OP_ABS && r_a[W-1])) ? r_conv :
                   (r_op == OP_ABS) ? r_a : w_sum[W-1:0];

    // SUB carry uses a direct compare so B=0 still reports no-borrow
    always_comb begin
        w_flags = '0;
        w_flags[FLAG_Z] = (w_res == '0);
        w_flags[FLAG_N] = w_res[W-1];
        w_flags[FLAG_V] = (r_op == OP_ADD) ? (r_a[W-1] == r_b[W-1]) && (w_res[W-1] != r_a[W-1]) :
                          (r_op == OP_SUB) ? (r_a[W-1] != r_b[W-1]) && (w_res[W-1] != r_a[W-1]) :
                          (r_a == {1'b1, {(W-1){1'b0}}});
        w_flags[FLAG_C] = (r_op == OP_ADD) ? w_sum[W] : (r_op == OP_SUB) && (r_a >= r_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_conv   <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_op <= op_t'(op);
                r_a  <= A;
                r_b  <= B;
            end
            if (r_state == S_CONV) r_conv <= (r_op == OP_ADD) ? r_b : w_comp;
            if (r_state == S_EXEC) begin
                r_result <= w_res;
                r_flags  <= w_flags;
            end
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign flags  = r_flags;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized scoreboard bench for alu_sequencer against an integer-arithmetic model
module tb_alu_sequencer;
    localparam int W = 6;
    localparam int M = 1 << W;
    localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, NEG = 2'd2, ABS = 2'd3;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, ack = 1'b0;
    logic [1:0]   op = '0;
    logic [W-1:0] A = '0, B = '0;
    logic         busy, done;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int checks = 0, errors = 0;
    logic [W+3:0] sb_q[$];
    logic         prev_done = 1'b0;
    logic [W+3:0] out_hold = '0;

    always #5 clk = ~clk;

    alu_sequencer #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B), .ack(ack),
        .busy(busy), .done(done), .result(result), .flags(flags)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {result, carry, overflow, negative, zero} from signed/unsigned integer arithmetic
    function automatic logic [W+3:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int ua, ub, sa, sb, r, s;
        logic c;
        ua = int'(a);
        ub = int'(b);
        sa = a[W-1] ? ua - M : ua;
        sb = b[W-1] ? ub - M : ub;
        c = 1'b0;
        case (o)
            ADD: begin r = ua + ub; c = (r >= M); s = sa + sb; end
            SUB: begin r = ua - ub; c = (ua >= ub); s = sa - sb; end
            NEG: begin r = -sa; s = -sa; end
            default: begin r = (sa < 0) ? -sa : sa; s = r; end
        endcase
        r = ((r % M) + M) % M;
        return {W'(r), c, (s > M/2 - 1) || (s < -M/2), r >= M/2, r == 0};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) prev_done = 1'b0;
        else begin
            if (done && !prev_done) begin
                if (sb_q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
                else chk("result_flags", 32'({result, flags}), 32'(sb_q.pop_front()));
            end else if (done) chk("hold_stable", 32'({result, flags}), 32'(out_hold));
            prev_done = done;
            out_hold = {result, flags};
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W+3:0] exp, input int hold, input bit noise);
        int lat;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        sb_q.push_back(exp);
        @(negedge clk);
        lat = 1;
        start = 1'b0;
        chk("accepted", 32'(busy), 32'd1);
        while (!done && lat < 8) begin
            start = noise ? 1'($urandom) : 1'b0;
            A = W'($urandom); B = W'($urandom); op = 2'($urandom);
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'd3);
        repeat (hold) begin
            start = noise ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        chk("done_held", 32'(done), 32'd1);
        ack = 1'b1; start = noise;
        @(negedge clk);
        ack = 1'b0; start = 1'b0;
        chk("idle_after_ack", 32'(busy), 32'd0);
        chk("done_low_after_ack", 32'(done), 32'd0);
    endtask

    initial begin
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_start", 32'(busy), 32'd0);

        run_op(ADD, 6'b011111, 6'b000001, {6'b100000, 4'b0110}, 0, 1'b0);
        run_op(SUB, 6'b000101, 6'b000011, {6'b000010, 4'b1000}, 1, 1'b0);
        run_op(SUB, 6'b000011, 6'b000101, {6'b111110, 4'b0010}, 0, 1'b0);
        run_op(NEG, 6'b100000, 6'b010101, {6'b100000, 4'b0110}, 0, 1'b0);
        run_op(ABS, 6'b111101, 6'b000000, {6'b000011, 4'b0000}, 0, 1'b0);
        run_op(ADD, 6'd5, 6'd9, model(ADD, 6'd5, 6'd9), 5, 1'b1);

        @(negedge clk);
        start = 1'b1; op = SUB; A = 6'd20; B = 6'd7;
        sb_q.push_back(model(SUB, 6'd20, 6'd7));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_flags", 32'(flags), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("no_done_after_reset", 32'(done), 32'd0);
        end

        begin
            logic [W-1:0] corner[6];
            corner = '{6'd0, 6'd1, 6'd31, 6'd32, 6'd33, 6'd63};
            for (int o = 0; o < 4; o++)
                for (int i = 0; i < 6; i++)
                    for (int j = 0; j < 6; j++)
                        run_op(2'(o), corner[i], corner[j], model(2'(o), corner[i], corner[j]), 0, 1'b0);
        end

        for (int n = 0; n < 3000; n++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom);
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ro, ra, rb, model(ro, ra, rb), int'($urandom_range(0, 2)), 1'($urandom));
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
